// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
//   Constants and types shared by the front-end of the RV64 core.
//
//   DEFAULT_XLEN     : architectural address/PC width
//   DEFAULT_RESET_PC : first fetch address after reset
//   INSTR_W          : instruction word width
//   fetch_state_t    : fetch FSM states (REQ, WAIT, DROP)
//   align_pc()       : clears the two low PC bits (targets are 4-byte aligned)
// -----------------------------------------------------------------------------
package core_pkg;

    localparam int          DEFAULT_XLEN     = 64;
    localparam logic [63:0] DEFAULT_RESET_PC = 64'h0000_0000_8000_0000;
    localparam int          INSTR_W          = 32;

    // REQ  : request outstanding, response will be used
    // WAIT : response parked in the skid buffer, no request issued
    // DROP : request outstanding whose response must be discarded
    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    function automatic logic [63:0] align_pc(input logic [63:0] pc);
        return {pc[63:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_skid.sv
// -----------------------------------------------------------------------------
// fetch_skid
//   One-entry buffer that parks a fetched instruction when the IF/ID register
//   is held by decode back-pressure.
//
//   clk        in   clock
//   reset      in   synchronous, active-high
//   load       in   capture load_pc/load_instr and mark the entry valid
//   drain      in   entry consumed by the IF/ID register this cycle
//   clear      in   flush (redirect); wins over load
//   load_pc    in   PC of the instruction being parked
//   load_instr in   instruction being parked
//   valid      out  entry holds an instruction
//   pc         out  parked PC
//   instr      out  parked instruction
// -----------------------------------------------------------------------------
module fetch_skid
    import core_pkg::*;
#(
    parameter int XLEN = DEFAULT_XLEN
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               drain,
    input  logic               clear,
    input  logic [XLEN-1:0]    load_pc,
    input  logic [INSTR_W-1:0] load_instr,
    output logic               valid,
    output logic [XLEN-1:0]    pc,
    output logic [INSTR_W-1:0] instr
);

    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
        end else if (clear || drain) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
        end
    end

    // NOTE: the payload is qualified by valid, so it carries no reset and
    // keeps the data flops plain enables.
    always_ff @(posedge clk) begin
        if (load) begin
            pc    <= load_pc;
            instr <= load_instr;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage: holds the PC, issues one request at a time on the
//   instruction bus, tolerates any memory latency, and hands each instruction
//   with its PC to decode through the registered IF/ID output. Redirects flush
//   the stage; a request already on the bus is never withdrawn, its response
//   is discarded instead (DROP state).
//
//   clk            in   clock
//   reset          in   synchronous, active-high
//   ireq_valid     out  fetch request outstanding
//   ireq_addr      out  fetch address, stable while ireq_valid
//   iresp_valid    in   response to the current request (may be same cycle)
//   iresp_data     in   instruction word
//   redirect_valid in   flush and restart at redirect_pc
//   redirect_pc    in   new PC, low two bits ignored
//   stall          in   decode cannot accept this cycle
//   out_valid      out  IF/ID holds an instruction
//   out_pc         out  PC of out_instr
//   out_instr      out  instruction to decode
// -----------------------------------------------------------------------------
module fetch_stage
    import core_pkg::*;
#(
    parameter int               XLEN     = DEFAULT_XLEN,
    parameter logic [XLEN-1:0]  RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
    input  logic               clk,
    input  logic               reset,
    output logic               ireq_valid,
    output logic [XLEN-1:0]    ireq_addr,
    input  logic               iresp_valid,
    input  logic [INSTR_W-1:0] iresp_data,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    input  logic               stall,
    output logic               out_valid,
    output logic [XLEN-1:0]    out_pc,
    output logic [INSTR_W-1:0] out_instr
);

    fetch_state_t        state;
    logic [XLEN-1:0]     pc;
    logic [XLEN-1:0]     req_addr;

    logic                slot_free;
    logic [XLEN-1:0]     pc_plus4;
    logic [XLEN-1:0]     redirect_target;
    logic                skid_load;
    logic                skid_drain;
    logic                skid_valid;
    logic [XLEN-1:0]     skid_pc;
    logic [INSTR_W-1:0]  skid_instr;

    // NOTE: every always_comb output gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        slot_free       = !out_valid || !stall;
        pc_plus4        = pc + XLEN'(4);  // wraps modulo 2^XLEN by design
        redirect_target = {redirect_pc[XLEN-1:2], 2'b00};
        ireq_valid      = (state == REQ) || (state == DROP);
        ireq_addr       = req_addr;
        skid_load       = 1'b0;
        skid_drain      = 1'b0;
        if (!redirect_valid) begin
            skid_load  = (state == REQ) && iresp_valid && !slot_free;
            skid_drain = (state == WAIT) && !stall;
        end
    end

    fetch_skid #(
        .XLEN (XLEN)
    ) u_skid (
        .clk        (clk),
        .reset      (reset),
        .load       (skid_load),
        .drain      (skid_drain),
        .clear      (redirect_valid),
        .load_pc    (req_addr),
        .load_instr (iresp_data),
        .valid      (skid_valid),
        .pc         (skid_pc),
        .instr      (skid_instr)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= REQ;
            pc        <= RESET_PC;
            req_addr  <= RESET_PC;
            out_valid <= 1'b0;
            out_pc    <= '0;
            out_instr <= '0;
        end else if (redirect_valid) begin
            // Redirect overrides stall: the IF/ID contents are wrong-path.
            out_valid <= 1'b0;
            pc        <= redirect_target;
            case (state)
                REQ: begin
                    if (iresp_valid) begin
                        req_addr <= redirect_target;
                    end else begin
                        state <= DROP;
                    end
                end
                WAIT: begin
                    req_addr <= redirect_target;
                    state    <= REQ;
                end
                DROP: begin
                    // The old request stays on the bus until it is answered.
                    if (iresp_valid) begin
                        req_addr <= redirect_target;
                        state    <= REQ;
                    end
                end
                default: begin
                    req_addr <= redirect_target;
                    state    <= REQ;
                end
            endcase
        end else begin
            case (state)
                REQ: begin
                    // In REQ, pc and req_addr always hold the same address.
                    if (iresp_valid) begin
                        pc       <= pc_plus4;
                        req_addr <= pc_plus4;
                        if (slot_free) begin
                            out_valid <= 1'b1;
                            out_pc    <= req_addr;
                            out_instr <= iresp_data;
                        end else begin
                            state <= WAIT;
                        end
                    end else if (slot_free) begin
                        out_valid <= 1'b0;
                    end
                end
                WAIT: begin
                    if (!stall) begin
                        out_valid <= skid_valid;
                        out_pc    <= skid_pc;
                        out_instr <= skid_instr;
                        state     <= REQ;
                    end
                end
                DROP: begin
                    if (slot_free) begin
                        out_valid <= 1'b0;
                    end
                    if (iresp_valid) begin
                        req_addr <= pc;
                        state    <= REQ;
                    end
                end
                default: begin
                    state <= REQ;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//   Directed bench for fetch_stage. The memory model answers either
//   automatically after mem_latency idle cycles (0 = same cycle) or under
//   manual control (mem_auto = 0, man_valid). Instruction words come from a
//   fixed image function of the address.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            reset;
    logic            ireq_valid;
    logic [XLEN-1:0] ireq_addr;
    logic            iresp_valid;
    logic [31:0]     iresp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            stall;
    logic            out_valid;
    logic [XLEN-1:0] out_pc;
    logic [31:0]     out_instr;

    logic mem_en;
    logic mem_auto;
    logic man_valid;
    int   mem_latency;
    int   wait_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_stage dut (
        .clk            (clk),
        .reset          (reset),
        .ireq_valid     (ireq_valid),
        .ireq_addr      (ireq_addr),
        .iresp_valid    (iresp_valid),
        .iresp_data     (iresp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .out_valid      (out_valid),
        .out_pc         (out_pc),
        .out_instr      (out_instr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] image(input logic [63:0] addr);
        return addr[31:0] ^ 32'h1357_9BDF;
    endfunction

    // Memory model: counts idle request cycles, answers after mem_latency.
    always_ff @(posedge clk) begin
        if (reset || !mem_en) begin
            wait_cnt <= 0;
        end else if (ireq_valid && !iresp_valid) begin
            wait_cnt <= wait_cnt + 1;
        end else begin
            wait_cnt <= 0;
        end
    end

    always_comb begin
        if (mem_auto) begin
            iresp_valid = mem_en && ireq_valid && (wait_cnt >= mem_latency);
        end else begin
            iresp_valid = man_valid && ireq_valid;
        end
        iresp_data = image(ireq_addr);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input int latency);
        reset          = 1'b1;
        mem_en         = 1'b0;
        mem_auto       = 1'b1;
        man_valid      = 1'b0;
        mem_latency    = latency;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    // After this returns the bench is inside the first post-reset cycle.
    task automatic release_reset();
        reset  = 1'b0;
        mem_en = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // ---- reset values, zero-latency streaming ----
        apply_reset(0);
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_pc", out_pc, 0);
        check("rst_out_instr", out_instr, 0);
        check("rst_ireq_addr", ireq_addr, 64'h8000_0000);
        @(posedge clk);
        #1;
        release_reset();
        @(negedge clk);
        check("c1_ireq_valid", ireq_valid, 1);
        check("c1_out_valid", out_valid, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            check("stream_valid", out_valid, 1);
            check("stream_pc", out_pc, 64'h8000_0000 + 64'(4 * i));
            check("stream_instr", out_instr, image(64'h8000_0000 + 64'(4 * i)));
        end

        // ---- 3-cycle memory latency: one instruction every 4 cycles ----
        apply_reset(3);
        release_reset();
        for (int c = 1; c <= 12; c++) begin
            if (c > 1) tick();
            @(negedge clk);
            check("lat_ireq_addr", ireq_addr, 64'h8000_0000 + 64'(4 * ((c - 1) / 4)));
            check("lat_out_valid", out_valid, (c >= 5 && (c - 5) % 4 == 0) ? 1 : 0);
            if (c >= 5 && (c - 5) % 4 == 0) begin
                check("lat_out_pc", out_pc, 64'h8000_0000 + 64'(4 * ((c - 5) / 4)));
                check("lat_out_instr", out_instr, image(64'h8000_0000 + 64'(4 * ((c - 5) / 4))));
            end
        end

        // ---- stall with a response in flight: skid holds it ----
        apply_reset(0);
        release_reset();
        tick();
        stall = 1'b1;
        @(negedge clk);
        check("stall_c2_pc", out_pc, 64'h8000_0000);
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            check("stall_hold_valid", out_valid, 1);
            check("stall_hold_pc", out_pc, 64'h8000_0000);
            check("stall_ireq_valid", ireq_valid, 0);
        end
        tick();
        stall = 1'b0;
        @(negedge clk);
        check("release_pc", out_pc, 64'h8000_0000);
        check("release_ireq_valid", ireq_valid, 0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            @(negedge clk);
            check("resume_valid", out_valid, 1);
            check("resume_pc", out_pc, 64'h8000_0000 + 64'(4 * i));
            check("resume_instr", out_instr, image(64'h8000_0000 + 64'(4 * i)));
        end

        // ---- redirect while the request to 8000_0010 is outstanding ----
        apply_reset(0);
        release_reset();
        repeat (4) tick();
        mem_auto       = 1'b0;
        man_valid      = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0103;
        @(negedge clk);
        check("rd_pending_addr", ireq_addr, 64'h8000_0010);
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("rd_out_cleared", out_valid, 0);
        check("rd_drop_ireq_valid", ireq_valid, 1);
        check("rd_drop_addr", ireq_addr, 64'h8000_0010);
        tick();
        man_valid = 1'b1;
        @(negedge clk);
        check("rd_drop_out_valid", out_valid, 0);
        tick();
        man_valid = 1'b0;
        mem_auto  = 1'b1;
        @(negedge clk);
        check("rd_discarded", out_valid, 0);
        check("rd_new_addr", ireq_addr, 64'h8000_0100);
        tick();
        @(negedge clk);
        check("rd_first_valid", out_valid, 1);
        check("rd_first_pc", out_pc, 64'h8000_0100);
        check("rd_first_instr", out_instr, image(64'h8000_0100));
        tick();
        @(negedge clk);
        check("rd_second_pc", out_pc, 64'h8000_0104);

        // ---- redirect + response + stall in the same cycle ----
        apply_reset(0);
        release_reset();
        tick();
        stall          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0200;
        tick();
        stall          = 1'b0;
        redirect_valid = 1'b0;
        @(negedge clk);
        check("rs_out_valid", out_valid, 0);
        check("rs_skid_empty", dut.skid_valid, 0);
        check("rs_ireq_valid", ireq_valid, 1);
        check("rs_ireq_addr", ireq_addr, 64'h8000_0200);
        tick();
        @(negedge clk);
        check("rs_first_pc", out_pc, 64'h8000_0200);
        check("rs_first_valid", out_valid, 1);
        tick();
        @(negedge clk);
        check("rs_second_pc", out_pc, 64'h8000_0204);

        // ---- PC wrap from all-ones-3 to zero ----
        apply_reset(0);
        release_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("wrap_out_valid", out_valid, 0);
        check("wrap_ireq_addr", ireq_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        tick();
        @(negedge clk);
        check("wrap_top_pc", out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        check("wrap_next_addr", ireq_addr, 64'h0);
        tick();
        @(negedge clk);
        check("wrap_zero_pc", out_pc, 64'h0);
        check("wrap_zero_instr", out_instr, image(64'h0));
        check("wrap_after_addr", ireq_addr, 64'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
